// File: rtl/config_scan_pkg.sv
// Shared types for the configuration scan chain.
package config_scan_pkg;

  localparam int unsigned STATE_W = 2;

  // Controller state encoding.
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/scan_shift_reg.sv
// Serial-in / parallel-out shift register with parallel load; MSB leaves as scan_out.
module scan_shift_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             scan_in,
  output logic [WIDTH-1:0] data,
  output logic             scan_out
);

  // Parallel load wins over shift; new serial bits enter at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end else if (shift_en) begin
      data <= {data[WIDTH-2:0], scan_in};
    end
  end

  assign scan_out = data[WIDTH-1];

endmodule

// File: rtl/config_scan_chain.sv
// Configuration scan chain: shifts a WIDTH-bit word in, then commits it to cfg_out atomically.
module config_scan_chain
  import config_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             capture,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  output logic [WIDTH-1:0] cfg_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shift_q;
  logic             load_c;
  logic             shift_c;

  // Shift-register controls: capture only honoured in IDLE, scan_en only in SHIFT.
  assign load_c  = (state == IDLE) && capture;
  assign shift_c = (state == SHIFT) && scan_en;
  assign busy    = (state != IDLE);

  scan_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .load_data (cfg_out),
    .shift_en  (shift_c),
    .scan_in   (scan_in),
    .data      (shift_q),
    .scan_out  (scan_out)
  );

  // Controller: shift counting, commit of the shifted word and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cfg_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (scan_en) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              state <= COMMIT;
            end
          end
        end
        COMMIT: begin
          cfg_out <= shift_q;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_scan_chain.sv
// Directed bench for config_scan_chain with WIDTH=8 and a queue-based scoreboard.
module tb_config_scan_chain;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         capture;
  logic         scan_en;
  logic         scan_in;
  logic         scan_out;
  logic [W-1:0] cfg_out;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_bit_q[$];

  config_scan_chain #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .capture  (capture),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .scan_out (scan_out),
    .cfg_out  (cfg_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Full load of word w; optional stall of stall_n cycles after stall_at bits; optional start/capture poke mid-shift.
  task automatic run_load(input logic [W-1:0] w, input int stall_at, input int stall_n,
                          input bit poke, input logic [W-1:0] old_cfg);
    int idx;
    int stalls;
    int busy_cyc;
    int edges;
    int dones;
    bit seen;
    logic [W-1:0] want;
    check("idle_busy", W'(busy), W'(0));
    exp_q.push_back(w);
    start = 1'b1; capture = 1'b0; scan_en = 1'b0;
    tick;
    start = 1'b0;
    idx = 0; stalls = 0; busy_cyc = 0; edges = 0; dones = 0; seen = 1'b0;
    if (busy) busy_cyc++;
    while (!seen && edges < 40) begin
      start = 1'b0; capture = 1'b0; scan_in = 1'b0;
      if (idx == stall_at && stalls < stall_n) begin
        scan_en = 1'b0;
        stalls++;
      end else begin
        scan_en = (idx < int'(W));
      end
      if (idx < int'(W)) scan_in = w[W-1-idx];
      if (poke && idx == 3) begin
        start = 1'b1;
        capture = 1'b1;
      end
      if (scan_en) idx++;
      tick;
      edges++;
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        dones++;
      end else begin
        check("cfg_stable", cfg_out, old_cfg);
      end
    end
    start = 1'b0; capture = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
    check("done_seen", W'(seen), W'(1));
    check("latency", W'(edges), W'(int'(W) + 1 + stall_n));
    check("busy_cycles", W'(busy_cyc), W'(int'(W) + 1 + stall_n));
    want = exp_q.pop_front();
    check("cfg_commit", cfg_out, want);
    tick;
    check("done_once", W'(done), W'(0));
    check("busy_after", W'(busy), W'(0));
    check("cfg_hold", cfg_out, want);
  endtask

  initial begin
    logic [W-1:0] rb;
    logic         b;
    logic [W-1:0] want;

    rst = 1'b1; start = 1'b0; capture = 1'b0; scan_en = 1'b0; scan_in = 1'b0;
    tick;
    tick;
    rst = 1'b0;
    check("rst_cfg", cfg_out, W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_scan_out", W'(scan_out), W'(0));

    // Basic load, then a second word, then a stalled load back to A5.
    run_load(8'hA5, -1, 0, 1'b0, 8'h00);
    run_load(8'h12, -1, 0, 1'b0, 8'hA5);
    run_load(8'hA5, 4, 3, 1'b0, 8'h12);

    // scan_en toggling in IDLE must not disturb anything.
    scan_en = 1'b1; scan_in = 1'b1;
    tick;
    tick;
    scan_en = 1'b0; scan_in = 1'b0;
    check("idle_scan_en_busy", W'(busy), W'(0));
    check("idle_scan_en_cfg", cfg_out, 8'hA5);

    // Reset after four shifts: no commit, everything back to zero.
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      scan_en = 1'b1; scan_in = 1'b1;
      tick;
    end
    scan_en = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_cfg", cfg_out, W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_done", W'(done), W'(0));
    check("midrst_scan_out", W'(scan_out), W'(0));
    tick;
    check("midrst_no_done", W'(done), W'(0));
    run_load(8'h3C, -1, 0, 1'b0, 8'h00);

    // start/capture pulsed during SHIFT are ignored.
    run_load(8'h96, -1, 0, 1'b1, 8'h3C);

    // Restore A5, then read it back while shifting in zeros.
    run_load(8'hA5, -1, 0, 1'b0, 8'h96);
    rb = 8'hA5;
    for (int i = 0; i < int'(W); i++) exp_bit_q.push_back(rb[W-1-i]);
    exp_q.push_back(8'h00);
    capture = 1'b1; start = 1'b1;
    tick;
    capture = 1'b0; start = 1'b0;
    check("rb_busy", W'(busy), W'(1));
    for (int i = 0; i < int'(W); i++) begin
      b = exp_bit_q.pop_front();
      check("rb_scan_out", W'(scan_out), W'(b));
      scan_en = 1'b1; scan_in = 1'b0;
      tick;
    end
    scan_en = 1'b0;
    check("rb_cfg_before_commit", cfg_out, 8'hA5);
    check("rb_scan_out_drained", W'(scan_out), W'(0));
    tick;
    want = exp_q.pop_front();
    check("rb_done", W'(done), W'(1));
    check("rb_cfg", cfg_out, want);
    tick;
    check("rb_done_once", W'(done), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
